rf_write_buffer: RTL and testbench

RF_WRITE_BUFFER -- requirements
Module: rf_write_buffer

---
 rtl/rf_wbuf_pkg.sv | 16 +
 rtl/rf_wbuf_match.sv | 53 +++++
 rtl/rf_write_buffer.sv | 144 ++++++++++++++
 tb/tb_rf_write_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_wbuf_pkg.sv
// rf_wbuf_pkg: shared constants and entry layout for the register-file
// write buffer.
//   RF_WBUF_ADDR_W / RF_WBUF_DATA_W : default register address/data widths
//   rf_wbuf_entry_t                 : {valid, addr, data} queue entry
package rf_wbuf_pkg;

  localparam int RF_WBUF_ADDR_W = 3;
  localparam int RF_WBUF_DATA_W = 32;

  typedef struct packed {
    logic                      valid;
    logic [RF_WBUF_ADDR_W-1:0] addr;
    logic [RF_WBUF_DATA_W-1:0] data;
  } rf_wbuf_entry_t;

endpackage

// File: rtl/rf_wbuf_match.sv
// rf_wbuf_match: combinational forwarding search over the write-buffer
// queue and the registered write stage.
// Ports:
//   valid_i  [DEPTH]        per-slot valid bits
//   addr_i   [DEPTH*ADDR_W] flattened slot addresses (slot i at i*ADDR_W)
//   data_i   [DEPTH*DATA_W] flattened slot data
//   rd_ptr_i                slot index of the oldest entry
//   we_i/waddr_i/wdata_i    registered register-file write stage
//   key_i                   lookup address
//   hit_o / data_o          match flag and youngest matching value (0 on miss)
module rf_wbuf_match
  import rf_wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RF_WBUF_ADDR_W,
  parameter int DATA_W = RF_WBUF_DATA_W
) (
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [DEPTH*ADDR_W-1:0] addr_i,
  input  logic [DEPTH*DATA_W-1:0] data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic [ADDR_W-1:0]       key_i,
  output logic                    hit_o,
  output logic [DATA_W-1:0]       data_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk from the write stage (oldest) through the queue oldest->youngest;
  // each later match overrides, so the youngest match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    if (we_i && (waddr_i == key_i)) begin
      hit_o  = 1'b1;
      data_o = wdata_i;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_i + PTR_W'(i);
      if (valid_i[idx] && (addr_i[idx*ADDR_W +: ADDR_W] == key_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rf_write_buffer.sv
// rf_write_buffer: FIFO of pending register-file writes drained one per
// cycle into a registered write port, with optional read forwarding.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   in_valid/in_ready        write request handshake (in_addr, in_data)
//   drain_en                 downstream permits a write this cycle
//   we/wAddr/wData           registered register-file write port
//   fwd_addr/fwd_hit/fwd_data forwarding lookup (youngest pending value)
//   count                    occupied entries
// Build option: define RF_WBUF_FWD_EN to enable forwarding; otherwise
// fwd_hit/fwd_data are tied to 0 and fwd_addr is ignored.
module rf_write_buffer
  import rf_wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RF_WBUF_ADDR_W,
  parameter int DATA_W = RF_WBUF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     we,
  output logic [ADDR_W-1:0]        wAddr,
  output logic [DATA_W-1:0]        wData,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              push, pop;

  // Full refuses pushes even when a pop is happening this edge.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = drain_en && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    we_d     = pop;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
      waddr_d           = addr_mem_q[rd_ptr_q];
      wdata_d           = data_mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Entry payload needs no reset: valid_q qualifies every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= in_addr;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign we    = we_q;
  assign wAddr = waddr_q;
  assign wData = wdata_q;
  assign count = count_q;

`ifdef RF_WBUF_FWD_EN
  logic [DEPTH*ADDR_W-1:0] addr_flat;
  logic [DEPTH*DATA_W-1:0] data_flat;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign addr_flat[g*ADDR_W +: ADDR_W] = addr_mem_q[g];
    assign data_flat[g*DATA_W +: DATA_W] = data_mem_q[g];
  end

  rf_wbuf_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match (
    .valid_i  (valid_q),
    .addr_i   (addr_flat),
    .data_i   (data_flat),
    .rd_ptr_i (rd_ptr_q),
    .we_i     (we_q),
    .waddr_i  (waddr_q),
    .wdata_i  (wdata_q),
    .key_i    (fwd_addr),
    .hit_o    (fwd_hit),
    .data_o   (fwd_data)
  );
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_addr;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_rf_write_buffer.sv
module tb_rf_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
`ifdef RF_WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] d38 [4];

  rf_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .we       (we),
    .wAddr    (wAddr),
    .wData    (wData),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    d38[0] = 32'h11111111;
    d38[1] = 32'hff00ff00;
    d38[2] = 32'hff00ff00;
    d38[3] = 32'h00ff00ff;

    // Reset held two edges with a request present.
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_addr  = 3'd5;
    in_data  = 32'hdeadbeef;
    drain_en = 1'b1;
    fwd_addr = 3'd5;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_we", we, 0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    drain_en = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_waddr", wAddr, 0);
    chk("rst_wdata", wData, 0);
    chk("rst_fwd_hit", fwd_hit, 0);

    // Fill to full, refuse a fifth, then drain in order.
    for (int i = 0; i < 4; i++) push_one(3'(i + 1), d38[i]);
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    chk("full_we", we, 0);
    fwd_addr = 3'd1;
    #1;
    chk("full_fwd_hit", fwd_hit, FWD);
    chk("full_fwd_data", fwd_data, FWD ? 32'h11111111 : 32'h0);
    in_valid = 1'b1;
    in_addr  = 3'd7;
    in_data  = 32'hdeadbeef;
    tick();
    chk("fifth_count", count, 4);
    in_valid = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we", we, 1);
      chk("drain_waddr", wAddr, i + 1);
      chk("drain_wdata", wData, d38[i]);
      chk("drain_count", count, 3 - i);
    end
    tick();
    chk("drained_we", we, 0);
    chk("drained_hold_waddr", wAddr, 4);
    chk("drained_hold_wdata", wData, 32'h00ff00ff);

    // No same-cycle pass-through on an empty buffer.
    push_one(3'd2, 32'h22);
    chk("pt_edgeN_we", we, 0);
    chk("pt_edgeN_count", count, 1);
    tick();
    chk("pt_edgeN1_we", we, 1);
    chk("pt_edgeN1_waddr", wAddr, 2);
    chk("pt_edgeN1_wdata", wData, 32'h22);
    chk("pt_edgeN1_count", count, 0);
    tick();
    chk("pt_after_we", we, 0);

    // Full with push and drain both requested.
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(3'(i), 32'h40 + 32'(i));
    chk("fp_full", count, 4);
    in_valid = 1'b1;
    in_addr  = 3'd4;
    in_data  = 32'h44;
    drain_en = 1'b1;
    tick();
    chk("fp_e1_count", count, 3);
    chk("fp_e1_waddr", wAddr, 0);
    chk("fp_e1_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("fp_e2_count", count, 3);
    chk("fp_e2_waddr", wAddr, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fp_drain_waddr", wAddr, i + 2);
      chk("fp_drain_wdata", wData, 32'h42 + 32'(i));
      chk("fp_drain_count", count, 2 - i);
    end
    tick();
    chk("fp_done_we", we, 0);

    // Duplicate address, youngest wins; then through the write stage.
    drain_en = 1'b0;
    fwd_addr = 3'd3;
    push_one(3'd3, 32'hA);
    push_one(3'd3, 32'hB);
    chk("dup_count", count, 2);
    chk("dup_fwd_hit", fwd_hit, FWD);
    chk("dup_fwd_data", fwd_data, FWD ? 32'hB : 32'h0);
    drain_en = 1'b1;
    tick();
    chk("dup_pop1_wdata", wData, 32'hA);
    chk("dup_pop1_fwd_data", fwd_data, FWD ? 32'hB : 32'h0);
    tick();
    chk("dup_pop2_wdata", wData, 32'hB);
    chk("dup_pop2_count", count, 0);
    chk("dup_wstage_hit", fwd_hit, FWD);
    chk("dup_wstage_data", fwd_data, FWD ? 32'hB : 32'h0);
    fwd_addr = 3'd2;
    #1;
    chk("miss_hit", fwd_hit, 0);
    chk("miss_data", fwd_data, 0);
    fwd_addr = 3'd3;
    tick();
    chk("wstage_gone_hit", fwd_hit, 0);

    // Reset mid-operation discards queued entries.
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(3'd3, 32'h60 + 32'(i));
    drain_en = 1'b1;
    tick();
    chk("pre_rst_count", count, 3);
    chk("pre_rst_we", we, 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_fwd_hit", fwd_hit, 0);
    reset_n  = 1'b1;
    drain_en = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    tick();
    chk("post_rst_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
